// File: rtl/prog_clock_divider_if.sv
// Divisor write port for prog_clock_divider: one shared request bus for all channels.
// A write transfers on a rising edge where WR_VALID and WR_READY are both 1; WR_READY may drop while a request waits.
interface prog_clock_divider_if #(
   parameter int WIDTH = 16,
   parameter int NCH   = 2
);
   localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

   logic             WR_VALID;
   logic [CW-1:0]    WR_CH;
   logic [WIDTH-1:0] WR_DIV;
   logic             WR_READY;

   modport master (output WR_VALID, output WR_CH, output WR_DIV, input WR_READY);
   modport slave  (input WR_VALID, input WR_CH, input WR_DIV, output WR_READY);
endinterface

// File: rtl/prog_clock_divider.sv
// Multi-channel programmable clock divider with glitch-free divisor updates at period wrap.
// Optional macro CLKDIV_TICK_EN adds the per-channel TICK period-end strobe output.
module prog_clock_divider #(
   parameter int WIDTH       = 16,
   parameter int NCH         = 2,
   parameter int DEFAULT_DIV = 20
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic [NCH-1:0]        ENABLE,
   prog_clock_divider_if.slave   wr,
   output logic [NCH-1:0]        dCLK
`ifdef CLKDIV_TICK_EN
   ,
   output logic [NCH-1:0]        TICK
`endif
);
   localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

   logic [WIDTH-1:0] d_q   [NCH];
   logic [WIDTH-1:0] d_d   [NCH];
   logic [WIDTH-1:0] cnt_q [NCH];
   logic [WIDTH-1:0] cnt_d [NCH];
   logic [WIDTH-1:0] pd_q  [NCH];
   logic [WIDTH-1:0] pd_d  [NCH];
   logic [WIDTH-1:0] e_cur [NCH];
   logic [NCH-1:0]   p_q, p_d;
   logic [NCH-1:0]   dclk_q, dclk_d;
   logic [NCH-1:0]   wrap;
   logic             wr_ready_c;
   logic             accept;

   // Divisors 0 and 1 are treated as 2 so every channel always toggles.
   function automatic logic [WIDTH-1:0] eff(input logic [WIDTH-1:0] d);
      return (d < WIDTH'(2)) ? WIDTH'(2) : d;
   endfunction

   always_comb begin
      wr_ready_c = 1'b1;
      for (int i = 0; i < NCH; i++) begin
         if (wr.WR_CH == CW'(i) && p_q[i]) wr_ready_c = 1'b0;
      end
   end

   assign wr.WR_READY = wr_ready_c;
   assign accept      = wr.WR_VALID & wr_ready_c;

   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         e_cur[i] = eff(d_q[i]);
         wrap[i]  = (cnt_q[i] == e_cur[i] - WIDTH'(1));
         d_d[i]   = d_q[i];
         cnt_d[i] = cnt_q[i];
         pd_d[i]  = pd_q[i];
         p_d[i]   = p_q[i];
         if (!ENABLE[i] || wrap[i]) begin
            cnt_d[i] = '0;
            if (p_q[i]) begin
               d_d[i] = pd_q[i];
               p_d[i] = 1'b0;
            end
         end else begin
            cnt_d[i] = cnt_q[i] + WIDTH'(1);
         end
         // Accept only happens with p_q clear, so it never races the apply above.
         if (accept && wr.WR_CH == CW'(i)) begin
            pd_d[i] = wr.WR_DIV;
            p_d[i]  = 1'b1;
         end
         dclk_d[i] = ENABLE[i] && (cnt_d[i] >= (eff(d_d[i]) >> 1));
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         for (int i = 0; i < NCH; i++) begin
            d_q[i]   <= WIDTH'(DEFAULT_DIV);
            cnt_q[i] <= '0;
            pd_q[i]  <= '0;
         end
         p_q    <= '0;
         dclk_q <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            d_q[i]   <= d_d[i];
            cnt_q[i] <= cnt_d[i];
            pd_q[i]  <= pd_d[i];
         end
         p_q    <= p_d;
         dclk_q <= dclk_d;
      end
   end

   assign dCLK = dclk_q;

`ifdef CLKDIV_TICK_EN
   assign TICK = ENABLE & wrap;
`endif
endmodule

// File: tb/tb_prog_clock_divider.sv
// Directed bench for prog_clock_divider; three channels so WR_CH=3 is an out-of-range index.
// Channel 2 stays disabled throughout; channels 0 and 1 carry the scenarios.
module tb_prog_clock_divider;
   logic       CLK;
   logic       RESET;
   logic [2:0] ENABLE;
   logic [2:0] dCLK;
`ifdef CLKDIV_TICK_EN
   logic [2:0] TICK;
`endif

   int n_total = 0;
   int n_bad   = 0;
   int k       = 0;
   int org [3];
   int per [3];
   logic [2:0] en_exp;

   prog_clock_divider_if #(.WIDTH(16), .NCH(3)) wr_if ();

   prog_clock_divider #(.WIDTH(16), .NCH(3), .DEFAULT_DIV(20)) dut (
      .CLK    (CLK),
      .RESET  (RESET),
      .ENABLE (ENABLE),
      .wr     (wr_if),
      .dCLK   (dCLK)
`ifdef CLKDIV_TICK_EN
      ,
      .TICK   (TICK)
`endif
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected phase of each channel from its hand-set period origin and length.
   function automatic logic [2:0] exp_dclk();
      logic [2:0] r;
      r = '0;
      for (int i = 0; i < 3; i++)
         if (en_exp[i]) r[i] = ((k - org[i]) % per[i]) >= (per[i] / 2);
      return r;
   endfunction

   function automatic logic [2:0] exp_tick();
      logic [2:0] r;
      r = '0;
      for (int i = 0; i < 3; i++)
         if (en_exp[i]) r[i] = ((k - org[i]) % per[i]) == (per[i] - 1);
      return r;
   endfunction

   task automatic run_to(input int target);
      while (k < target) begin
         @(negedge CLK);
         k++;
         check($sformatf("dclk_k%0d", k), 32'(dCLK), 32'(exp_dclk()));
`ifdef CLKDIV_TICK_EN
         check($sformatf("tick_k%0d", k), 32'(TICK), 32'(exp_tick()));
`endif
      end
   endtask

   task automatic drive_wr(input logic v, input logic [1:0] ch, input logic [15:0] dv);
      wr_if.WR_VALID = v;
      wr_if.WR_CH    = ch;
      wr_if.WR_DIV   = dv;
      #1;
   endtask

   task automatic restart_model();
      k      = 0;
      org    = '{0, 0, 0};
      per    = '{20, 20, 20};
      en_exp = 3'b011;
   endtask

   initial begin
      RESET  = 1'b0;
      ENABLE = 3'b011;
      drive_wr(1'b0, 2'd0, 16'd0);
      repeat (2) @(negedge CLK);
      check("reset_dclk", 32'(dCLK), 32'd0);
      check("reset_ready", 32'(wr_if.WR_READY), 32'd1);
`ifdef CLKDIV_TICK_EN
      check("reset_tick", 32'(TICK), 32'd0);
`endif
      RESET = 1'b1;
      restart_model();

      // Default divisor: 10 low, 10 high on both channels.
      run_to(45);
      drive_wr(1'b1, 2'd0, 16'd5);
      check("ch0_ready_before_wr", 32'(wr_if.WR_READY), 32'd1);
      run_to(46);
      drive_wr(1'b0, 2'd0, 16'd0);
      check("ch0_ready_pending", 32'(wr_if.WR_READY), 32'd0);

      // Second ch0 write is refused; ch1 takes a write while ch0 is busy.
      run_to(49);
      drive_wr(1'b1, 2'd0, 16'd9);
      check("ch0_ready_refuse", 32'(wr_if.WR_READY), 32'd0);
      run_to(50);
      drive_wr(1'b1, 2'd1, 16'd0);
      check("ch1_ready_free", 32'(wr_if.WR_READY), 32'd1);
      run_to(51);
      drive_wr(1'b0, 2'd0, 16'd0);
      run_to(59);
      check("ch0_ready_last_cycle", 32'(wr_if.WR_READY), 32'd0);
      org[0] = 60; per[0] = 5;
      org[1] = 60; per[1] = 2;
      run_to(60);
      check("ch0_ready_after_wrap", 32'(wr_if.WR_READY), 32'd1);

      // Write in ch1's wrap cycle stays pending for a full period.
      run_to(61);
      drive_wr(1'b1, 2'd1, 16'd1);
      check("ch1_ready_wrapcyc", 32'(wr_if.WR_READY), 32'd1);
      run_to(62);
      drive_wr(1'b0, 2'd1, 16'd0);
      check("ch1_pending_k62", 32'(wr_if.WR_READY), 32'd0);
      run_to(63);
      check("ch1_pending_k63", 32'(wr_if.WR_READY), 32'd0);
      run_to(64);
      check("ch1_applied_k64", 32'(wr_if.WR_READY), 32'd1);

      // Out-of-range channel: accepted and dropped.
      run_to(65);
      drive_wr(1'b1, 2'd3, 16'd2);
      check("oob_ready", 32'(wr_if.WR_READY), 32'd1);
      run_to(66);
      drive_wr(1'b0, 2'd0, 16'd0);
      check("oob_no_pending", 32'(wr_if.WR_READY), 32'd1);

      // Pending divisor 6 applied by disabling ch0, then a clean restart.
      run_to(81);
      drive_wr(1'b1, 2'd0, 16'd6);
      check("ch0_ready_k81", 32'(wr_if.WR_READY), 32'd1);
      run_to(82);
      drive_wr(1'b0, 2'd0, 16'd0);
      ENABLE    = 3'b010;
      en_exp[0] = 1'b0;
      run_to(83);
      check("ch0_applied_on_disable", 32'(wr_if.WR_READY), 32'd1);
      run_to(85);
      ENABLE    = 3'b011;
      en_exp[0] = 1'b1;
      org[0]    = 85;
      per[0]    = 6;

      // Pending divisor 7 must be lost in the reset pulse.
      run_to(96);
      drive_wr(1'b1, 2'd0, 16'd7);
      check("ch0_ready_k96", 32'(wr_if.WR_READY), 32'd1);
      run_to(97);
      drive_wr(1'b0, 2'd0, 16'd0);
      run_to(98);
      check("ch0_pending_k98", 32'(wr_if.WR_READY), 32'd0);
      run_to(99);
      #1;
      RESET = 1'b0;
      #1;
      check("pulse_dclk", 32'(dCLK), 32'd0);
      check("pulse_ready", 32'(wr_if.WR_READY), 32'd1);
`ifdef CLKDIV_TICK_EN
      check("pulse_tick", 32'(TICK), 32'd0);
`endif
      #1;
      RESET = 1'b1;
      restart_model();
      run_to(45);
      check("post_reset_ready", 32'(wr_if.WR_READY), 32'd1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
